// File: rtl/ram_cycle_ctrl_if.sv
// 68000-side bus bundle for the expansion SRAM cycle sequencer.
// master = CPU/top-level side, slave = ram_cycle_ctrl.
interface ram_cycle_ctrl_if;
    logic       cpu_nas;
    logic       cpu_nuds;
    logic       cpu_nlds;
    logic       cpu_rnw;
    logic [2:0] AH;
    logic       configured;
    logic [2:0] base_address;
    logic       ram_nce1;
    logic       ram_nce2;
    logic       ram_noe;
    logic       ram_nwe_hi;
    logic       ram_nwe_lo;
    logic       ram_dtack;
    logic       ram_hit;

    modport master (
        output cpu_nas, cpu_nuds, cpu_nlds, cpu_rnw, AH, configured, base_address,
        input  ram_nce1, ram_nce2, ram_noe, ram_nwe_hi, ram_nwe_lo, ram_dtack, ram_hit
    );

    modport slave (
        input  cpu_nas, cpu_nuds, cpu_nlds, cpu_rnw, AH, configured, base_address,
        output ram_nce1, ram_nce2, ram_noe, ram_nwe_hi, ram_nwe_lo, ram_dtack, ram_hit
    );
endinterface

// File: rtl/ram_cycle_ctrl.sv
// Expansion SRAM bus-cycle sequencer: decodes 68000 cycles against the autoconfig base
// and drives CE/OE/WE plus DTACK. Define RAM2_EN to decode a second 2 MB bank at base+1.
module ram_cycle_ctrl #(
    parameter int WAIT_STATES = 0
) (
    input logic             cpu_clk,
    input logic             cpu_nreset,
    ram_cycle_ctrl_if.slave bus
);

    if (WAIT_STATES < 0 || WAIT_STATES > 3) begin : g_ws_range
        $error("ram_cycle_ctrl: WAIT_STATES must be 0..3");
    end

    localparam logic [1:0] WS_LD = WAIT_STATES[1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ACK
    } state_e;

    state_e     state_q;
    logic       nas_z_q;
    logic [1:0] wcnt_q;
    logic       rnw_l_q;
    logic       bank_l;
    logic       hit1;
    logic       hit2;
    logic       hit;
    logic       start;
    logic       active;

    assign hit1 = bus.configured & (bus.AH == bus.base_address);

`ifdef RAM2_EN
    logic [2:0] base_p1;
    logic       bank_l_q;
    assign base_p1 = bus.base_address + 3'd1;
    assign hit2    = bus.configured & (bus.AH == base_p1);
    assign bank_l  = bank_l_q;
`else
    assign hit2    = 1'b0;
    assign bank_l  = 1'b0;
`endif

    // Gated by reset so the top-level data-bus direction stays quiet while held in reset.
    assign hit   = cpu_nreset & (hit1 | hit2);
    assign start = nas_z_q & ~bus.cpu_nas & hit;

    always_ff @(posedge cpu_clk or negedge cpu_nreset) begin
        if (!cpu_nreset) begin
            state_q  <= S_IDLE;
            nas_z_q  <= 1'b1;
            wcnt_q   <= 2'd0;
            rnw_l_q  <= 1'b1;
`ifdef RAM2_EN
            bank_l_q <= 1'b0;
`endif
        end else begin
            nas_z_q <= bus.cpu_nas;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_START;
                        rnw_l_q  <= bus.cpu_rnw;
`ifdef RAM2_EN
                        bank_l_q <= hit2;
`endif
                    end
                end
                S_START: begin
                    if (bus.cpu_nas) begin
                        state_q <= S_IDLE;
                    end else begin
                        wcnt_q  <= WS_LD;
                        state_q <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.cpu_nas) begin
                        state_q <= S_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q - 2'd1;
                        if (wcnt_q == 2'd1) state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (bus.cpu_nas) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes follow /AS, /UDS, /LDS combinationally so they drop without waiting for a clock.
    assign active = cpu_nreset & (state_q != S_IDLE) & ~bus.cpu_nas;

    assign bus.ram_hit    = hit;
    assign bus.ram_nce1   = ~(active & ~bank_l);
`ifdef RAM2_EN
    assign bus.ram_nce2   = ~(active & bank_l);
`else
    assign bus.ram_nce2   = 1'b1;
`endif
    assign bus.ram_noe    = ~(active & rnw_l_q);
    assign bus.ram_nwe_hi = ~(active & ~rnw_l_q & ~bus.cpu_nuds);
    assign bus.ram_nwe_lo = ~(active & ~rnw_l_q & ~bus.cpu_nlds);
    assign bus.ram_dtack  = cpu_nreset & (state_q == S_ACK) & ~bus.cpu_nas;

endmodule

// File: tb/tb_ram_cycle_ctrl.sv
// Bench for ram_cycle_ctrl: four instances (WAIT_STATES 0..3) share one stimulus and are
// checked against a cycle-counting reference model after every edge and input change.
module tb_ram_cycle_ctrl;

    logic       cpu_clk = 1'b0;
    logic       cpu_nreset;
    logic       nas, nuds, nlds, rnw, configured;
    logic [2:0] ah, base;
    logic [3:0] o_nce1, o_nce2, o_noe, o_nwe_hi, o_nwe_lo, o_dtack, o_hit;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 cpu_clk = ~cpu_clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        ram_cycle_ctrl_if bus ();
        assign bus.cpu_nas      = nas;
        assign bus.cpu_nuds     = nuds;
        assign bus.cpu_nlds     = nlds;
        assign bus.cpu_rnw      = rnw;
        assign bus.AH           = ah;
        assign bus.configured   = configured;
        assign bus.base_address = base;
        assign o_nce1[k]   = bus.ram_nce1;
        assign o_nce2[k]   = bus.ram_nce2;
        assign o_noe[k]    = bus.ram_noe;
        assign o_nwe_hi[k] = bus.ram_nwe_hi;
        assign o_nwe_lo[k] = bus.ram_nwe_lo;
        assign o_dtack[k]  = bus.ram_dtack;
        assign o_hit[k]    = bus.ram_hit;

        ram_cycle_ctrl #(.WAIT_STATES(k)) u_dut (
            .cpu_clk    (cpu_clk),
            .cpu_nreset (cpu_nreset),
            .bus        (bus)
        );
    end

    // Reference model: a cycle is either open or not; m_n counts edges since its start edge.
    bit m_cyc, m_seen_hi, m_rnw, m_bank;
    int m_n;

    function automatic bit m_hit2();
        logic [2:0] b1;
        b1 = base + 3'd1;
`ifdef RAM2_EN
        return configured && (ah == b1);
`else
        return 1'b0 && (ah == b1);
`endif
    endfunction

    function automatic bit m_hit();
        return configured && ((ah == base) || m_hit2());
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_seen_hi = 1; m_rnw = 1; m_bank = 0; m_n = 0;
    endtask

    task automatic model_edge();
        if (!cpu_nreset) begin
            model_reset();
            return;
        end
        if (!m_cyc) begin
            if (m_seen_hi && !nas && m_hit()) begin
                m_cyc = 1; m_n = 0; m_rnw = rnw; m_bank = m_hit2();
            end
        end else if (nas) begin
            m_cyc = 0;
        end else begin
            m_n++;
        end
        m_seen_hi = nas;
    endtask

    task automatic chk(string tag, int k, logic obs, logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s ws=%0d t=%0t observed=%b expected=%b", tag, k, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        bit act;
        bit rst_ok;
        rst_ok = (cpu_nreset === 1'b1);
        act = rst_ok && m_cyc && !nas;
        for (int k = 0; k < 4; k++) begin
            chk("ram_hit",    k, o_hit[k],    rst_ok && m_hit());
            chk("ram_nce1",   k, o_nce1[k],   !(act && !m_bank));
`ifdef RAM2_EN
            chk("ram_nce2",   k, o_nce2[k],   !(act && m_bank));
`else
            chk("ram_nce2",   k, o_nce2[k],   1'b1);
`endif
            chk("ram_noe",    k, o_noe[k],    !(act && m_rnw));
            chk("ram_nwe_hi", k, o_nwe_hi[k], !(act && !m_rnw && !nuds));
            chk("ram_nwe_lo", k, o_nwe_lo[k], !(act && !m_rnw && !nlds));
            chk("ram_dtack",  k, o_dtack[k],  act && (m_n >= k + 1));
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    initial begin
        int sel;
        cpu_nreset = 1'b0;
        nas = 1; nuds = 1; nlds = 1; rnw = 1; configured = 1; base = 3'b001; ah = 3'b001;
        model_reset();
        settle();
        repeat (2) tick();
        cpu_nreset = 1'b1;
        repeat (2) tick();

        // read, /AS held low well past DTACK, then released between edges
        nas = 0; nuds = 0; nlds = 0; settle();
        repeat (6) tick();
        nas = 1; nuds = 1; nlds = 1; settle();
        tick();

        // word write with late data strobes
        rnw = 0; nas = 0; settle();
        tick();
        nuds = 0; nlds = 0; settle();
        repeat (4) tick();
        nuds = 1; nlds = 1; settle();
        tick();
        nas = 1; settle();
        tick();

        // byte write, /LDS only
        nas = 0; nlds = 0; settle();
        repeat (5) tick();
        nas = 1; nlds = 1; settle();
        tick();

        // not configured, then base+1 (second bank only with RAM2_EN)
        rnw = 1; configured = 0; nas = 0; nuds = 0; nlds = 0; settle();
        repeat (3) tick();
        nas = 1; settle(); tick();
        configured = 1; ah = 3'b010; nas = 0; settle();
        repeat (3) tick();
        base = 3'b101; configured = 0; settle();   // decode change mid-cycle
        repeat (2) tick();
        nas = 1; settle(); tick();

        // base+1 wrapping past 3'b111
        configured = 1; base = 3'b111; ah = 3'b000; nas = 0; settle();
        repeat (5) tick();
        nas = 1; settle(); tick();
        base = 3'b001; ah = 3'b001;

        // abort before DTACK, immediately followed by a normal cycle
        nas = 0; settle();
        tick(); tick();
        nas = 1; settle();
        tick();
        nas = 0; settle();
        repeat (6) tick();
        nas = 1; settle(); tick();

        // reset in the middle of ACK
        nas = 0; settle();
        repeat (5) tick();
        cpu_nreset = 1'b0; model_reset(); settle();
        nas = 1; settle();
        tick();
        cpu_nreset = 1'b1; settle();
        tick();
        nas = 0; settle();
        repeat (5) tick();
        nas = 1; settle(); tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            nas  = ($urandom_range(0, 99) < 25);
            rnw  = $urandom_range(0, 1);
            nuds = $urandom_range(0, 1);
            nlds = $urandom_range(0, 1);
            if ($urandom_range(0, 99) < 8)  configured = ~configured;
            if ($urandom_range(0, 99) < 10) base = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel < 6)      ah = base;
            else if (sel < 8) ah = base + 3'd1;
            else              ah = 3'($urandom_range(0, 7));
            settle();
            if ($urandom_range(0, 3) == 0) begin
                nuds = $urandom_range(0, 1);
                nlds = $urandom_range(0, 1);
                if ($urandom_range(0, 3) == 0) nas = 1;
                settle();
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
